c64_bus_sched: RTL
==================

// Module: c64_bus_sched
// PURPOSE
//  Bus-cycle scheduler for the C64 system bus. Divides dot_clk into phi0 cycles; in each cycle, owns the
//  phi0-low half for the VIC-II and grants the phi0-high half to the 6510, the expansion DMA master or the VIC.
//  Generates BA/AEC/RDY with the 3-cycle BA warning the 6510 needs to finish pending writes.
//  Sits between vicii (requests), mos6510 (RDY/AEC) and the bus address/data muxes in c64.
// PARAMETERS
//  DOTS      8   dot_clk periods per phi0 cycle; even, >=4
//  BA_LEAD   3   phi0 cycles between BA assertion and first stolen phi2 half; 1..7
//  STEAL_W   16  width of the stolen-cycle counter
// PORTS
//  dot_clk        in   1        pixel clock, sole clock
//  reset          in   1        synchronous, active-high
//  vic_req        in   1        VIC needs phi2 halves (badline/sprite fetch); level, held while needed
//  dma_req        in   1        expansion DMA request; level
//  phi0           out  1        0 = VIC half, 1 = CPU/DMA half
//  cycle_start    out  1        1-dot strobe on first dot of each phi0 cycle
//  phi2_start     out  1        1-dot strobe on first dot of phi0-high half
//  ba             out  1        1 = VIC has claimed the bus (drives RDY low)
//  aec            out  1        1 = CPU/DMA side drives bus this dot; 0 = VIC drives
//  cpu_rdy        out  1        6510 RDY; = ~ba & ~dma_grant
//  dma_grant      out  1        expansion master owns phi2 halves
//  steal_cnt      out  STEAL_W  saturating count of phi2 halves taken by VIC
// BEHAVIOUR
//  Reset (sync): dot_cnt=0, state=CPU, lead_cnt=0, steal_cnt=0; outputs phi0=0, ba=0, aec=0, cpu_rdy=1,
//   dma_grant=0, cycle_start=0, phi2_start=0. Reset asserted mid-steal/mid-DMA aborts immediately, no drain.
//  dot_cnt: 0..DOTS-1, +1 per dot_clk, wraps DOTS-1 -> 0. phi0 = (dot_cnt >= DOTS/2).
//  cycle_start = (dot_cnt==0), phi2_start = (dot_cnt==DOTS/2); both low in the first cycle after reset
//   (dot_cnt==0 from reset does not raise cycle_start until the first wrap).
//  Decisions: state, ba, dma_grant change only on the edge where dot_cnt wraps to 0 (boundary), using
//   vic_req/dma_req sampled at that edge. Requests changing mid-cycle are ignored until next boundary.
//  States (at boundary):
//   CPU:       vic_req -> BA_WAIT, ba=1, lead_cnt=BA_LEAD; else dma_req -> DMA, dma_grant=1; else stay.
//   BA_WAIT:   !vic_req -> CPU, ba=0 (no cycle stolen); else lead_cnt-1; when lead_cnt reaches 0 -> VIC_STEAL.
//   VIC_STEAL: !vic_req -> (dma_req ? DMA : CPU), ba=0; else stay.
//   DMA:       vic_req -> BA_WAIT, dma_grant=0, ba=1 (DMA master obeys BA like the CPU);
//              else !dma_req -> CPU, dma_grant=0; else stay.
//  Priority at a boundary: vic_req > dma_req > CPU. Simultaneous vic_req & dma_req from CPU -> BA_WAIT.
//  aec = phi0 & (state != VIC_STEAL). In BA_WAIT the CPU keeps aec for BA_LEAD phi2 halves so pending
//   writes complete; with ba rising at boundary k, first phi2 half with aec=0 is in cycle k+BA_LEAD.
//  steal_cnt: +1 at each phi2_start while state==VIC_STEAL; saturates at all-ones, never wraps.
//  All outputs registered or decoded from registers only; no combinational path from vic_req/dma_req.
// TESTING
//  1 Reset 3 dots then release, no requests -> phi0 low dots 0-3, high 4-7, period 8; aec==phi0; cpu_rdy=1.
//  2 vic_req=1 at boundary k, held 5 cycles -> ba=1 from k; aec high in phi2 of k..k+2, low in phi2 of
//    k+3,k+4 (BA_LEAD=3); steal_cnt=2; ba=0 after boundary where vic_req seen low.
//  3 vic_req pulse 1 cycle (low by next boundary) -> ba high exactly 1 cycle, no aec loss, steal_cnt=0.
//  4 dma_req=1 -> dma_grant=1, cpu_rdy=0 next boundary; vic_req raised mid-DMA -> dma_grant=0, ba=1, steal
//    3 cycles later; vic_req drops with dma_req still 1 -> back to DMA.
//  5 vic_req & dma_req asserted same boundary -> BA_WAIT, dma_grant stays 0.
//  6 STEAL_W=4, hold vic_req 40 cycles -> steal_cnt saturates at 15; reset in VIC_STEAL -> all reset values next edge.

Source files
------------

// File: rtl/c64_bus_sched.sv
`default_nettype none
// ============================================================================
// Module      : c64_bus_sched
// Description : C64 bus-cycle scheduler. Splits dot_clk into phi0 cycles and
//               arbitrates the phi2 half between the 6510, expansion DMA and VIC.
// Revision    : 1.0 - initial release
// ============================================================================
module c64_bus_sched #(
  parameter int DOTS    = 8,
  parameter int BA_LEAD = 3,
  parameter int STEAL_W = 16
) (
  input  logic               dot_clk,
  input  logic               reset,
  input  logic               vic_req,
  input  logic               dma_req,
  output logic               phi0,
  output logic               cycle_start,
  output logic               phi2_start,
  output logic               ba,
  output logic               aec,
  output logic               cpu_rdy,
  output logic               dma_grant,
  output logic [STEAL_W-1:0] steal_cnt
);

  localparam int                 c_cnt_w = $clog2(DOTS);
  localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(DOTS / 2);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DOTS - 1);
  localparam logic [2:0]         c_lead  = 3'(BA_LEAD);

  typedef enum logic [1:0] {
    ST_CPU       = 2'd0,
    ST_BA_WAIT   = 2'd1,
    ST_VIC_STEAL = 2'd2,
    ST_DMA       = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_dot_cnt;
  logic                 r_started;
  logic [2:0]           r_lead_cnt;
  logic                 r_ba;
  logic                 r_dma_grant;
  logic [STEAL_W-1:0]   r_steal_cnt;
  logic                 w_boundary;

  assign w_boundary = (r_dot_cnt == c_last);

  // Dot counter; r_started masks the strobes until the first wrap after reset.
  always_ff @(posedge dot_clk) begin
    if (reset) begin
      r_dot_cnt <= '0;
      r_started <= 1'b0;
    end else if (w_boundary) begin
      r_dot_cnt <= '0;
      r_started <= 1'b1;
    end else begin
      r_dot_cnt <= r_dot_cnt + 1'b1;
    end
  end

  // Ownership decisions are taken only on the wrap edge, so a request that
  // changes mid-cycle waits for the next boundary.
  always_ff @(posedge dot_clk) begin
    if (reset) begin
      r_state     <= ST_CPU;
      r_lead_cnt  <= '0;
      r_ba        <= 1'b0;
      r_dma_grant <= 1'b0;
    end else if (w_boundary) begin
      case (r_state)
        ST_CPU: begin
          if (vic_req) begin
            r_state    <= ST_BA_WAIT;
            r_ba       <= 1'b1;
            r_lead_cnt <= c_lead;
          end else if (dma_req) begin
            r_state     <= ST_DMA;
            r_dma_grant <= 1'b1;
          end
        end
        ST_BA_WAIT: begin
          if (!vic_req) begin
            r_state    <= ST_CPU;
            r_ba       <= 1'b0;
            r_lead_cnt <= '0;
          end else begin
            r_lead_cnt <= r_lead_cnt - 1'b1;
            if (r_lead_cnt == 3'd1) begin
              r_state <= ST_VIC_STEAL;
            end
          end
        end
        ST_VIC_STEAL: begin
          if (!vic_req) begin
            r_ba <= 1'b0;
            if (dma_req) begin
              r_state     <= ST_DMA;
              r_dma_grant <= 1'b1;
            end else begin
              r_state <= ST_CPU;
            end
          end
        end
        ST_DMA: begin
          // The expansion master honours BA exactly like the 6510 does.
          if (vic_req) begin
            r_state     <= ST_BA_WAIT;
            r_dma_grant <= 1'b0;
            r_ba        <= 1'b1;
            r_lead_cnt  <= c_lead;
          end else if (!dma_req) begin
            r_state     <= ST_CPU;
            r_dma_grant <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge dot_clk) begin
    if (reset) begin
      r_steal_cnt <= '0;
    end else if ((r_dot_cnt == c_half) && (r_state == ST_VIC_STEAL) &&
                 (r_steal_cnt != {STEAL_W{1'b1}})) begin
      r_steal_cnt <= r_steal_cnt + 1'b1;
    end
  end

  assign phi0        = (r_dot_cnt >= c_half);
  assign cycle_start = r_started & (r_dot_cnt == '0);
  assign phi2_start  = r_started & (r_dot_cnt == c_half);
  assign ba          = r_ba;
  assign dma_grant   = r_dma_grant;
  assign cpu_rdy     = ~r_ba & ~r_dma_grant;
  assign aec         = phi0 & (r_state != ST_VIC_STEAL);
  assign steal_cnt   = r_steal_cnt;

endmodule
`default_nettype wire
